// File: rtl/accel_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : accel_seq_pkg
//  Description : Shared types and constants for the accelerometer sequencer:
//                state encoding, WHO_AM_I probe, output register base and
//                the power-up configuration table.
//  Revision    : 1.0  initial release
// ============================================================================
package accel_seq_pkg;

    typedef enum logic [2:0] {
        S_WHOAMI = 3'd0,
        S_INIT   = 3'd1,
        S_READ   = 3'd2,
        S_WAIT   = 3'd3,
        S_PAUSE  = 3'd4,
        S_ERROR  = 3'd5
    } seq_state_e;

    // Read bit + WHO_AM_I address 0x0F, followed by a dummy data byte
    localparam logic [15:0] c_who_am_i_frame = 16'h8F00;
    localparam logic [7:0]  c_who_am_i_value = 8'h33;

    // Address of OUT_X_L; axis i lives at c_out_x_l_base + 2*i
    localparam logic [5:0]  c_out_x_l_base   = 6'h28;

    // Frame lengths minus one
    localparam logic [5:0]  c_nbits_short    = 6'd15;
    localparam logic [5:0]  c_nbits_read     = 6'd23;

    // Configuration writes issued once after a successful identity check
    localparam int          c_init_len       = 3;
    localparam logic [15:0] c_init_table [c_init_len] = '{16'h2077, 16'h1FC0, 16'h2388};

    // Read frame for one axis: read bit, auto-increment bit, address, 16 dummy bits
    function automatic logic [31:0] read_frame(input logic [1:0] axis);
        logic [5:0] addr;
        addr = c_out_x_l_base + {3'b000, axis, 1'b0};
        return {8'h00, 1'b1, 1'b1, addr, 16'h0000};
    endfunction

endpackage : accel_seq_pkg
`default_nettype wire

// File: rtl/accel_led_map.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : accel_led_map
//  Description : Maps a signed 8-bit sample byte to an 8-LED display, either
//                as a single lit position or as a thermometer bar.
//  Revision    : 1.0  initial release
// ============================================================================
module accel_led_map #(
    parameter int LED_MODE = 0
) (
    input  logic [7:0] i_h,
    output logic [7:0] o_led
);

    // Flipping the sign bit turns -128..127 into 0..255, top 3 bits pick the slot
    logic [7:0] w_biased;
    logic [2:0] w_k;

    assign w_biased = i_h + 8'h80;
    assign w_k      = w_biased[7:5];

    generate
        if (LED_MODE == 0) begin : g_onehot
            assign o_led = 8'd1 << w_k;
        end else begin : g_bar
            assign o_led = 8'hFF >> (3'd7 - w_k);
        end
    endgenerate

endmodule : accel_led_map
`default_nettype wire

// File: rtl/accel_multi_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : accel_multi_sequencer
//  Description : Drives an SPI master to identify and configure an
//                accelerometer, then periodically reads up to three axes,
//                publishing them together with a sample_valid pulse and an
//                LED rendering of one axis.
//  Revision    : 1.0  initial release
// ============================================================================
module accel_multi_sequencer
    import accel_seq_pkg::*;
#(
    parameter int N_AXES   = 3,
    parameter int POLL_DIV = 100000,
    parameter int TIMEOUT  = 4096,
    parameter int LED_MODE = 0,
    parameter int LED_AXIS = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    output logic [31:0]           spi_mosi_data,
    output logic [5:0]            spi_nbits,
    output logic                  spi_request,
    input  logic [31:0]           spi_miso_data,
    input  logic                  spi_ready,
    output logic [16*N_AXES-1:0]  axis_data,
    output logic                  sample_valid,
    output logic [7:0]            led_out,
    output logic                  error
);

    localparam logic [31:0] c_timeout_last = 32'(TIMEOUT - 1);
    localparam logic [31:0] c_poll_last    = 32'(POLL_DIV - 1);
    localparam logic [1:0]  c_last_axis    = 2'(N_AXES - 1);
    localparam logic [1:0]  c_last_init    = 2'(c_init_len - 1);

    seq_state_e           r_state_q, w_state_d;
    seq_state_e           r_ret_q, w_ret_d;
    logic [1:0]           r_init_idx_q, w_init_idx_d;
    logic [1:0]           r_axis_q, w_axis_d;
    logic [31:0]          r_cnt_q, w_cnt_d;
    logic [31:0]          r_mosi_q, w_mosi_d;
    logic [5:0]           r_nbits_q, w_nbits_d;
    logic                 r_req_q, w_req_d;
    logic [16*N_AXES-1:0] r_shadow_q, w_shadow_d;
    logic [16*N_AXES-1:0] r_axis_data_q, w_axis_data_d;
    logic                 r_valid_q, w_valid_d;
    logic [7:0]           r_led_q, w_led_d;
    logic                 r_error_q, w_error_d;

    logic [15:0]          w_sample;
    logic [16*N_AXES-1:0] w_merged;
    logic [7:0]           w_led_map;
    logic                 w_ready_ok;
    logic                 w_unused;

    // The device returns OUT_L first then OUT_H; swap into a signed 16-bit word
    assign w_sample   = {spi_miso_data[7:0], spi_miso_data[15:8]};
    // A ready coinciding with the request pulse belongs to no frame of ours
    assign w_ready_ok = spi_ready && !r_req_q;
    assign w_unused   = &{1'b0, spi_miso_data[31:16]};

    // Shadow set with the axis currently in flight replaced by the new sample
    always_comb begin
        w_merged = r_shadow_q;
        for (int i = 0; i < N_AXES; i++) begin
            if (r_axis_q == 2'(i)) begin
                w_merged[16*i +: 16] = w_sample;
            end
        end
    end

    accel_led_map #(
        .LED_MODE (LED_MODE)
    ) u_led_map (
        .i_h   (w_merged[16*LED_AXIS+8 +: 8]),
        .o_led (w_led_map)
    );

    // Sequencer next-state and output decode
    always_comb begin
        w_state_d     = r_state_q;
        w_ret_d       = r_ret_q;
        w_init_idx_d  = r_init_idx_q;
        w_axis_d      = r_axis_q;
        w_cnt_d       = r_cnt_q;
        w_mosi_d      = r_mosi_q;
        w_nbits_d     = r_nbits_q;
        w_req_d       = 1'b0;
        w_shadow_d    = r_shadow_q;
        w_axis_data_d = r_axis_data_q;
        w_valid_d     = 1'b0;
        w_led_d       = r_led_q;
        w_error_d     = r_error_q;

        case (r_state_q)
            S_WHOAMI: begin
                w_mosi_d  = {16'h0000, c_who_am_i_frame};
                w_nbits_d = c_nbits_short;
                w_req_d   = 1'b1;
                w_ret_d   = S_WHOAMI;
                w_cnt_d   = 32'd0;
                w_state_d = S_WAIT;
            end
            S_INIT: begin
                w_mosi_d  = {16'h0000, c_init_table[r_init_idx_q]};
                w_nbits_d = c_nbits_short;
                w_req_d   = 1'b1;
                w_ret_d   = S_INIT;
                w_cnt_d   = 32'd0;
                w_state_d = S_WAIT;
            end
            S_READ: begin
                w_mosi_d  = read_frame(r_axis_q);
                w_nbits_d = c_nbits_read;
                w_req_d   = 1'b1;
                w_ret_d   = S_READ;
                w_cnt_d   = 32'd0;
                w_state_d = S_WAIT;
            end
            S_WAIT: begin
                if (w_ready_ok) begin
                    case (r_ret_q)
                        S_WHOAMI: begin
                            if (spi_miso_data[7:0] == c_who_am_i_value) begin
                                w_led_d      = spi_miso_data[7:0];
                                w_init_idx_d = 2'd0;
                                w_state_d    = S_INIT;
                            end else begin
                                w_error_d = 1'b1;
                                w_led_d   = 8'hA5;
                                w_state_d = S_ERROR;
                            end
                        end
                        S_INIT: begin
                            if (r_init_idx_q == c_last_init) begin
                                w_axis_d  = 2'd0;
                                w_state_d = S_READ;
                            end else begin
                                w_init_idx_d = r_init_idx_q + 2'd1;
                                w_state_d    = S_INIT;
                            end
                        end
                        S_READ: begin
                            w_shadow_d = w_merged;
                            if (r_axis_q == c_last_axis) begin
                                w_axis_data_d = w_merged;
                                w_valid_d     = 1'b1;
                                w_led_d       = w_led_map;
                                w_cnt_d       = 32'd0;
                                w_state_d     = S_PAUSE;
                            end else begin
                                w_axis_d  = r_axis_q + 2'd1;
                                w_state_d = S_READ;
                            end
                        end
                        default: begin
                            w_error_d = 1'b1;
                            w_led_d   = 8'hA5;
                            w_state_d = S_ERROR;
                        end
                    endcase
                end else if (r_cnt_q == c_timeout_last) begin
                    w_error_d = 1'b1;
                    w_led_d   = 8'hA5;
                    w_state_d = S_ERROR;
                end else begin
                    w_cnt_d = r_cnt_q + 32'd1;
                end
            end
            S_PAUSE: begin
                if (r_cnt_q == c_poll_last) begin
                    w_axis_d  = 2'd0;
                    w_state_d = S_READ;
                end else begin
                    w_cnt_d = r_cnt_q + 32'd1;
                end
            end
            S_ERROR: begin
                w_error_d = 1'b1;
                w_led_d   = 8'hA5;
            end
            default: begin
                w_error_d = 1'b1;
                w_led_d   = 8'hA5;
                w_state_d = S_ERROR;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state_q     <= S_WHOAMI;
            r_ret_q       <= S_WHOAMI;
            r_init_idx_q  <= 2'd0;
            r_axis_q      <= 2'd0;
            r_cnt_q       <= 32'd0;
            r_mosi_q      <= 32'd0;
            r_nbits_q     <= 6'd0;
            r_req_q       <= 1'b0;
            r_shadow_q    <= '0;
            r_axis_data_q <= '0;
            r_valid_q     <= 1'b0;
            r_led_q       <= 8'd0;
            r_error_q     <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_ret_q       <= w_ret_d;
            r_init_idx_q  <= w_init_idx_d;
            r_axis_q      <= w_axis_d;
            r_cnt_q       <= w_cnt_d;
            r_mosi_q      <= w_mosi_d;
            r_nbits_q     <= w_nbits_d;
            r_req_q       <= w_req_d;
            r_shadow_q    <= w_shadow_d;
            r_axis_data_q <= w_axis_data_d;
            r_valid_q     <= w_valid_d;
            r_led_q       <= w_led_d;
            r_error_q     <= w_error_d;
        end
    end

    assign spi_mosi_data = r_mosi_q;
    assign spi_nbits     = r_nbits_q;
    assign spi_request   = r_req_q;
    assign axis_data     = r_axis_data_q;
    assign sample_valid  = r_valid_q;
    assign led_out       = r_led_q;
    assign error         = r_error_q;

endmodule : accel_multi_sequencer
`default_nettype wire

// File: tb/tb_accel_multi_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_accel_multi_sequencer
//  Description : Self-checking bench: LED map vector table, full sequencing
//                with an SPI slave model and reference sample/LED model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_accel_multi_sequencer;

    localparam int N_AXES   = 3;
    localparam int POLL_DIV = 20;
    localparam int TIMEOUT  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] miso = 32'd0;
    logic        ready = 1'b0;

    logic [31:0] mosi0, mosi1;
    logic [5:0]  nbits0, nbits1;
    logic        req0, req1;
    logic [47:0] axis0, axis1;
    logic        sv0, sv1;
    logic [7:0]  led0, led1;
    logic        err0, err1;

    logic [7:0]  map_h = 8'd0;
    logic [7:0]  map_o0, map_o1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    accel_multi_sequencer #(
        .N_AXES(N_AXES), .POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT), .LED_MODE(0), .LED_AXIS(0)
    ) dut (
        .clk_in(clk), .rst_in(rst), .spi_mosi_data(mosi0), .spi_nbits(nbits0),
        .spi_request(req0), .spi_miso_data(miso), .spi_ready(ready),
        .axis_data(axis0), .sample_valid(sv0), .led_out(led0), .error(err0)
    );

    accel_multi_sequencer #(
        .N_AXES(N_AXES), .POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT), .LED_MODE(1), .LED_AXIS(0)
    ) dut_bar (
        .clk_in(clk), .rst_in(rst), .spi_mosi_data(mosi1), .spi_nbits(nbits1),
        .spi_request(req1), .spi_miso_data(miso), .spi_ready(ready),
        .axis_data(axis1), .sample_valid(sv1), .led_out(led1), .error(err1)
    );

    accel_led_map #(.LED_MODE(0)) u_map0 (.i_h(map_h), .o_led(map_o0));
    accel_led_map #(.LED_MODE(1)) u_map1 (.i_h(map_h), .o_led(map_o1));

    typedef struct {
        logic [7:0] h;
        logic [7:0] e0;
        logic [7:0] e1;
    } led_vec_t;

    led_vec_t tbl [9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Display model: signed byte -128..127 split into eight equal bins
    function automatic logic [7:0] led_ref(input logic [7:0] h, input int mode);
        int k;
        k = ((int'(h) + 128) % 256) / 32;
        if (mode == 0) return 8'(1 << k);
        return 8'((1 << (k + 1)) - 1);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input int limit, output logic [31:0] d, output logic [5:0] nb, output bit ok);
        ok = 1'b0; d = 32'd0; nb = 6'd0;
        for (int i = 0; i < limit; i++) begin
            if (req0) begin
                d = mosi0; nb = nbits0; ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic respond(input logic [31:0] rsp, input int dly, input logic [31:0] ed);
        if (dly > 0) repeat (dly) @(negedge clk);
        check("mosi_hold", 64'(mosi0), 64'(ed));
        ready = 1'b1; miso = rsp;
        @(negedge clk);
        ready = 1'b0; miso = $urandom;
    endtask

    task automatic expect_frame(input string nm, input logic [31:0] ed, input logic [5:0] en,
                                input logic [31:0] rsp, input int dly);
        logic [31:0] d; logic [5:0] nb; bit ok;
        wait_req(400, d, nb, ok);
        check({nm, "_seen"}, 64'(ok), 64'd1);
        if (ok) begin
            check({nm, "_data"}, 64'(d), 64'(ed));
            check({nm, "_nbits"}, 64'(nb), 64'(en));
            respond(rsp, dly, ed);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_mosi"},  64'(mosi0),  64'd0);
        check({nm, "_nbits"}, 64'(nbits0), 64'd0);
        check({nm, "_req"},   64'(req0),   64'd0);
        check({nm, "_axis"},  64'(axis0),  64'd0);
        check({nm, "_valid"}, 64'(sv0),    64'd0);
        check({nm, "_led"},   64'(led0),   64'd0);
        check({nm, "_err"},   64'(err0),   64'd0);
    endtask

    // Release reset and walk the identity probe plus the configuration writes
    task automatic bring_up(input logic [7:0] who);
        int n;
        rst = 1'b0;
        n = 0;
        while (!req0 && n < 10) begin @(negedge clk); n++; end
        check("req_latency", 64'(n), 64'd1);
        expect_frame("whoami", 32'h8F00, 6'd15, {24'($urandom), who}, 2);
    endtask

    task automatic do_init();
        expect_frame("init0", 32'h2077, 6'd15, $urandom, 1);
        expect_frame("init1", 32'h1FC0, 6'd15, $urandom, 3);
        expect_frame("init2", 32'h2388, 6'd15, $urandom, 2);
    endtask

    // One full sample set; r* are the 16-bit words the device shifts back
    task automatic do_set(input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2,
                          input int glitch_axis, input int dly);
        logic [15:0] r [3];
        logic [47:0] exp_axis;
        logic [7:0]  h;
        logic [31:0] d; logic [5:0] nb; bit ok;
        r[0] = r0; r[1] = r1; r[2] = r2;
        exp_axis = 48'd0;
        for (int a = 0; a < N_AXES; a++) begin
            logic [31:0] ef;
            ef = 32'(8'hE8 + 2 * a) << 16;
            exp_axis[16*a +: 16] = {r[a][7:0], r[a][15:8]};
            if (a == glitch_axis) begin
                wait_req(400, d, nb, ok);
                check("glitch_seen", 64'(ok), 64'd1);
                respond({16'($urandom), ~r[a]}, 0, ef);
                respond({16'($urandom), r[a]}, 2, ef);
            end else begin
                expect_frame($sformatf("read%0d", a), ef, 6'd23, {16'($urandom), r[a]}, dly);
            end
        end
        for (int i = 0; i < 10 && !sv0; i++) @(negedge clk);
        h = exp_axis[15:8];
        check("valid_seen", 64'(sv0), 64'd1);
        check("axis_data", 64'(axis0), 64'(exp_axis));
        check("led_mode0", 64'(led0), 64'(led_ref(h, 0)));
        check("led_mode1", 64'(led1), 64'(led_ref(h, 1)));
        @(negedge clk);
        check("valid_pulse", 64'(sv0), 64'd0);
    endtask

    // Count cycles from the sample_valid pulse to the next read request
    task automatic pause_measure(input bit inject);
        int n;
        n = 1;
        while (!req0 && n < 200) begin
            if (inject && n == 4) begin ready = 1'b1; miso = 32'h0000_3333; end
            if (inject && n == 5) ready = 1'b0;
            @(negedge clk);
            n++;
        end
        ready = 1'b0;
        check("pause_len", 64'(n), 64'(POLL_DIV + 1));
    endtask

    initial begin
        int nreq;
        logic [31:0] d; logic [5:0] nb; bit ok;

        // LED mapping vectors
        tbl[0] = '{8'h80, 8'h01, 8'h01};
        tbl[1] = '{8'h00, 8'h10, 8'h1F};
        tbl[2] = '{8'h7F, 8'h80, 8'hFF};
        tbl[3] = '{8'hA0, 8'h02, 8'h03};
        tbl[4] = '{8'h60, 8'h80, 8'hFF};
        tbl[5] = '{8'hFF, 8'h08, 8'h0F};
        tbl[6] = '{8'h20, 8'h20, 8'h3F};
        tbl[7] = '{8'hC0, 8'h04, 8'h07};
        tbl[8] = '{8'h9F, 8'h01, 8'h01};
        for (int i = 0; i < 9; i++) begin
            map_h = tbl[i].h;
            #1;
            check($sformatf("ledtbl_m0_%0d", i), 64'(map_o0), 64'(tbl[i].e0));
            check($sformatf("ledtbl_m1_%0d", i), 64'(map_o1), 64'(tbl[i].e1));
        end
        for (int i = 0; i < 40; i++) begin
            map_h = 8'($urandom);
            #1;
            check("ledrnd_m0", 64'(map_o0), 64'(led_ref(map_h, 0)));
            check("ledrnd_m1", 64'(map_o1), 64'(led_ref(map_h, 1)));
        end

        // Reset state
        tick(3);
        check_reset_vals("reset");

        // Identity, configuration, first sample set with a same-cycle ready on axis 1
        bring_up(8'h33);
        do_init();
        check("led_whoami", 64'(led0), 64'h33);
        do_set(16'h3412, 16'h7856, 16'hBC9A, 1, 2);
        pause_measure(1'b1);

        // Boundary LED bins on axis 0
        do_set({8'($urandom), 8'h80}, 16'($urandom), 16'($urandom), -1, 1);
        pause_measure(1'b0);
        do_set({8'($urandom), 8'h00}, 16'($urandom), 16'($urandom), -1, 3);
        pause_measure(1'b0);
        do_set({8'($urandom), 8'h7F}, 16'($urandom), 16'($urandom), -1, 1);
        pause_measure(1'b0);

        // Random sets
        for (int s = 0; s < 6; s++) begin
            do_set(16'($urandom), 16'($urandom), 16'($urandom), -1, int'($urandom_range(1, 8)));
        end

        // Reset while the axis 1 frame is outstanding
        expect_frame("pre_rst_read0", 32'hE80000, 6'd23, $urandom, 1);
        wait_req(400, d, nb, ok);
        check("axis1_req_seen", 64'(ok), 64'd1);
        check("axis1_req_data", 64'(d), 64'hEA0000);
        tick(1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        tick(1);
        bring_up(8'h33);
        do_init();
        do_set(16'($urandom), 16'($urandom), 16'($urandom), -1, 2);

        // Withheld ready: timeout into the error state
        wait_req(400, d, nb, ok);
        check("to_req_seen", 64'(ok), 64'd1);
        tick(TIMEOUT - 3);
        check("to_not_early", 64'(err0), 64'd0);
        tick(6);
        check("to_err", 64'(err0), 64'd1);
        check("to_led", 64'(led0), 64'hA5);
        nreq = 0;
        for (int i = 0; i < 300; i++) begin @(negedge clk); if (req0) nreq++; end
        check("to_no_req", 64'(nreq), 64'd0);

        // Wrong identity byte
        rst = 1'b1;
        tick(2);
        bring_up(8'h32);
        tick(1);
        check("id_err", 64'(err0), 64'd1);
        check("id_led", 64'(led0), 64'hA5);
        nreq = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (req0) nreq++;
            if (i == 5000) begin ready = 1'b1; miso = 32'h33; end
            if (i == 5001) ready = 1'b0;
        end
        check("id_no_req", 64'(nreq), 64'd0);
        check("id_err_sticky", 64'(err0), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule : tb_accel_multi_sequencer
`default_nettype wire
